// File: rtl/oam_dma.sv
// OAM DMA engine: decodes the source-page register, then copies OAM_LEN bytes
// from {page,00} into OAM while isolating the core from the memory bus.
//
// state | meaning
// IDLE  | core passthrough, no transfer
// DELAY | one start-up cycle, bus still passthrough
// RD    | DMA reads source byte idx into byte_buf
// WR    | DMA writes byte_buf to OAM_BASE+idx
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter int          OAM_LEN      = 160,
  parameter logic [7:0]  ECHO_LO      = 8'hE0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_r_addr,
  input  logic [15:0] cpu_w_addr,
  input  logic [7:0]  cpu_w_data,
  input  logic        cpu_w_wen,
  output logic [7:0]  cpu_r_data,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_w_data,
  output logic        mem_w_wen,
  input  logic [7:0]  mem_r_data,
  output logic        dma_active,
  output logic [7:0]  dma_src
);

  localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

  typedef enum logic [1:0] {IDLE, DELAY, RD, WR} state_t;

  state_t     state_q, state_d;
  logic [7:0] src_page_q, src_page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] byte_buf_q, byte_buf_d;

  logic       reg_hit;
  logic [7:0] eff_page;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      src_page_q <= 8'h00;
      idx_q      <= 8'h00;
      byte_buf_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      src_page_q <= src_page_d;
      idx_q      <= idx_d;
      byte_buf_q <= byte_buf_d;
    end
  end

  assign reg_hit  = cpu_w_wen && (cpu_w_addr == DMA_REG_ADDR);
  // Echo RAM pages alias onto work RAM 0x20 pages lower.
  assign eff_page = (src_page_q >= ECHO_LO) ? (src_page_q - 8'h20) : src_page_q;

  always_comb begin
    state_d    = state_q;
    src_page_d = src_page_q;
    idx_d      = idx_q;
    byte_buf_d = byte_buf_q;
    mem_addr   = cpu_w_wen ? cpu_w_addr : cpu_r_addr;
    mem_w_data = cpu_w_data;
    mem_w_wen  = cpu_w_wen;
    cpu_r_data = mem_r_data;
    dma_active = 1'b0;

    case (state_q)
      IDLE: ;
      DELAY: begin
        dma_active = 1'b1;
        state_d    = RD;
      end
      RD: begin
        dma_active = 1'b1;
        mem_addr   = {eff_page, idx_q};
        mem_w_data = 8'h00;
        mem_w_wen  = 1'b0;
        cpu_r_data = 8'hFF;
        byte_buf_d = mem_r_data;
        state_d    = WR;
      end
      WR: begin
        dma_active = 1'b1;
        mem_addr   = OAM_BASE + {8'h00, idx_q};
        mem_w_data = byte_buf_q;
        mem_w_wen  = 1'b1;
        cpu_r_data = 8'hFF;
        if (idx_q == LAST_IDX) begin
          idx_d   = 8'h00;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = RD;
        end
      end
      default: state_d = IDLE;
    endcase

    // A register write restarts the transfer and never reaches memory.
    if (reg_hit) begin
      src_page_d = cpu_w_data;
      idx_d      = 8'h00;
      state_d    = DELAY;
      mem_w_wen  = 1'b0;
    end

    if (cpu_r_addr == DMA_REG_ADDR) cpu_r_data = src_page_q;

    if (rst) begin
      mem_addr   = 16'h0000;
      mem_w_data = 8'h00;
      mem_w_wen  = 1'b0;
      cpu_r_data = 8'hFF;
      dma_active = 1'b0;
    end
  end

  assign dma_src = src_page_q;

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- OAM DMA engine between the sm83 core memory port and the single-port memory bus.
- Decodes core writes to the DMA register and holds the source page.
- When armed, takes over the memory port and copies 160 bytes from {page,8'h00} to OAM.
- While active, the core sees an isolated bus. The core has no stall input.

Parameters:
- DMA_REG_ADDR, 16'hFF46, address of DMA source-page register
- OAM_BASE, 16'hFE00, destination base address
- OAM_LEN, 160, bytes per transfer
- ECHO_LO, 8'hE0, source pages >= this are mapped down by 8'h20

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cpu_r_addr  in  16  core read address
- cpu_w_addr  in  16  core write address
- cpu_w_data  in  8  core write data
- cpu_w_wen  in  1  core write enable
- cpu_r_data  out  8  read data returned to core
- mem_addr  out  16  memory address
- mem_w_data  out  8  memory write data
- mem_w_wen  out  1  memory write enable
- mem_r_data  in  8  memory read data (combinational on mem_addr)
- dma_active  out  1  transfer in progress (DELAY/RD/WR)
- dma_src  out  8  current source-page register value

Behaviour:
- One clock is one bus cycle.
- Registers: state, src_page (8b), idx (8b), byte_buf (8b).
- Reset (async, rst=1) values:
  - state=IDLE, src_page=8'h00, idx=0, byte_buf=0.
  - Outputs: dma_active=0, dma_src=8'h00, mem_w_wen=0, cpu_r_data=8'hFF.
  - mem_addr=16'h0000, mem_w_data=8'h00.
- Register hit: cpu_w_wen && cpu_w_addr==DMA_REG_ADDR, in any state.
  - src_page<=cpu_w_data, idx<=0, state<=DELAY.
  - The write is absorbed (mem_w_wen=0 that cycle). Hit is the highest-priority event.
- FF46 readback, any state: cpu_r_addr==DMA_REG_ADDR gives cpu_r_data=src_page combinationally.
- States:
  - IDLE: passthrough.
    - mem_addr = cpu_w_wen ? cpu_w_addr : cpu_r_addr.
    - mem_w_data=cpu_w_data, mem_w_wen=cpu_w_wen (except register hit), cpu_r_data=mem_r_data.
  - DELAY: one cycle. Bus still passthrough, dma_active=1. Next state is RD.
  - RD: DMA owns bus.
    - mem_addr={eff_page,idx}, mem_w_wen=0, byte_buf<=mem_r_data. Next state is WR.
    - eff_page = src_page>=ECHO_LO ? src_page-8'h20 : src_page.
  - WR: DMA owns bus.
    - mem_addr=OAM_BASE+idx, mem_w_data=byte_buf, mem_w_wen=1.
    - If idx==OAM_LEN-1: idx<=0, state<=IDLE. Else idx<=idx+1, state<=RD.
- Core isolation in RD/WR:
  - cpu_r_data=8'hFF (except FF46 readback).
  - Core writes are dropped, except the register hit, which restarts the transfer.
- Timing: register hit sampled at edge ending cycle N.
  - Cycle N+1: DELAY.
  - Byte k read in cycle N+2+2k, written in N+3+2k.
  - Last write in N+321.
  - dma_active=0 from cycle N+322.
  - Total occupancy 321 cycles.
- Restart mid-transfer: the register hit overrides the WR/RD next state. Bytes already written stay written; the copy restarts from idx 0 with the new page.
- Reset mid-transfer: returns to IDLE immediately. mem_w_wen drops asynchronously and no further OAM writes occur.
- idx never exceeds OAM_LEN-1. No wrap into FEA0+.

Test Plan:
1. Reset check: assert rst mid-cycle -> dma_active=0, mem_w_wen=0, dma_src=00; core read of FF46 returns 00; passthrough read of C123 returns memory content.
2. Full copy: preload C000..C09F with i^8'h5A, core writes C0 to FF46 at cycle N -> memory never sees FF46 write; FE00..FE9F = i^8'h5A; dma_active high for cycles N+1..N+321; 160 mem writes, all to FE00..FE9F.
3. Echo mapping: write E1 to FF46 -> reads come from C100..C19F; FF46 readback = E1.
4. Core isolation: during transfer, core reads 8000 -> FF; core writes 55 to C000 -> C000 unchanged; core read of FF46 -> current page.
5. Restart: after idx 50 written, core writes D0 to FF46 -> one DELAY cycle, then reads restart at D000; final FE00..FE9F = D000..D09F; total dma_active extends to 321 cycles after the restart write.
6. Reset mid-transfer at idx 80: no writes after reset edge, FE50+ keep old values, bus returns to passthrough.
